// File: rtl/image_capture_sequencer.sv
// Frame-buffer write sequencer: zero-fills the buffer on a clear request and
// streams one frame of pixels to consecutive addresses per frame_start.
module image_capture_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 19,
  parameter int FRAME_PIXELS = 307200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  image_capture_enabled,
  input  logic                  clear_memory,
  input  logic                  frame_start,
  input  logic                  pixel_valid,
  input  logic [DATA_WIDTH-1:0] pixel_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  clear_busy,
  output logic                  capture_busy,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
  output logic                  frame_error
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CLEAR   = 2'd1;
  localparam logic [1:0] S_ARMED   = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(FRAME_PIXELS - 1);

  logic [1:0]            state;
  logic [1:0]            state_nx;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] cnt_nx;
  logic                  clr_prev;
  logic                  clr_go;
  logic                  wr;
  logic                  pix_wr;
  logic                  last;
  logic                  restart;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;

  // A clear request is ignored while a clear is already running.
  assign clr_go = clear_memory & ~clr_prev & (state != S_CLEAR);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    wr       = 1'b0;
    pix_wr   = 1'b0;
    last     = 1'b0;
    restart  = 1'b0;
    waddr    = cnt;
    wdata    = pixel_data;
    if (clr_go) begin
      state_nx = S_CLEAR;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (image_capture_enabled)
            state_nx = S_ARMED;
        end
        S_CLEAR: begin
          wr    = 1'b1;
          wdata = '0;
          if (cnt == LAST) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        S_ARMED: begin
          if (!image_capture_enabled) begin
            state_nx = S_IDLE;
          end else if (frame_start) begin
            state_nx = S_CAPTURE;
            cnt_nx   = '0;
            waddr    = '0;
            pix_wr   = pixel_valid;
          end
        end
        S_CAPTURE: begin
          if (frame_start) begin
            restart = 1'b1;
            cnt_nx  = '0;
            waddr   = '0;
          end
          pix_wr = pixel_valid;
        end
        default: state_nx = S_IDLE;
      endcase
      // Pixel write bookkeeping shared by frame start and mid-frame pixels.
      if (pix_wr) begin
        wr = 1'b1;
        if (waddr == LAST) begin
          last     = 1'b1;
          cnt_nx   = '0;
          state_nx = image_capture_enabled ? S_ARMED : S_IDLE;
        end else begin
          cnt_nx = waddr + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      clr_prev     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      clear_busy   <= 1'b0;
      capture_busy <= 1'b0;
      frame_done   <= 1'b0;
      frame_count  <= '0;
      frame_error  <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      clr_prev     <= clear_memory;
      mem_we       <= wr;
      clear_busy   <= (state == S_CLEAR);
      capture_busy <= (state == S_ARMED) || (state == S_CAPTURE);
      frame_done   <= last;
      if (wr) begin
        mem_addr  <= waddr;
        mem_wdata <= wdata;
      end
      if (last)
        frame_count <= frame_count + 16'd1;
      if (clr_go)
        frame_error <= 1'b0;
      else if (restart)
        frame_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_image_capture_sequencer.sv
// Randomized bench for image_capture_sequencer against a behavioural model
// of the frame-buffer write sequence (FRAME_PIXELS=16).
module tb_image_capture_sequencer;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int FP = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          image_capture_enabled = 1'b0;
  logic          clear_memory = 1'b0;
  logic          frame_start = 1'b0;
  logic          pixel_valid = 1'b0;
  logic [DW-1:0] pixel_data = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          clear_busy;
  logic          capture_busy;
  logic          frame_done;
  logic [15:0]   frame_count;
  logic          frame_error;

  image_capture_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_PIXELS(FP)
  ) dut (
    .clk(clk), .reset(reset),
    .image_capture_enabled(image_capture_enabled),
    .clear_memory(clear_memory), .frame_start(frame_start),
    .pixel_valid(pixel_valid), .pixel_data(pixel_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .clear_busy(clear_busy), .capture_busy(capture_busy),
    .frame_done(frame_done), .frame_count(frame_count),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=idle 1=clear 2=armed 3=capture.
  int          md;
  int          ctr;
  bit          pclr;
  bit          rise;
  bit          e_we;
  int          e_addr;
  logic [31:0] e_wd;
  bit          e_cb;
  bit          e_capb;
  bit          e_done;
  int          e_cnt;
  bit          e_err;
  bit          started = 0;

  always @(posedge clk) begin
    started = 1;
    if (reset) begin
      md = 0; ctr = 0; pclr = 0;
      e_we = 0; e_addr = 0; e_wd = 0;
      e_cb = 0; e_capb = 0; e_done = 0;
      e_cnt = 0; e_err = 0;
    end else begin
      rise   = clear_memory && !pclr;
      pclr   = clear_memory;
      e_cb   = (md == 1);
      e_capb = (md == 2) || (md == 3);
      e_we   = 0;
      e_done = 0;
      if (rise && md != 1) begin
        md = 1; ctr = 0; e_err = 0;
      end else if (md == 1) begin
        e_we = 1; e_addr = ctr; e_wd = 0;
        ctr++;
        if (ctr == FP) begin md = 0; ctr = 0; end
      end else if (md == 0) begin
        if (image_capture_enabled) md = 2;
      end else if (md == 2 && !image_capture_enabled) begin
        md = 0;
      end else begin
        if (frame_start) begin
          if (md == 3) e_err = 1;
          md = 3; ctr = 0;
        end
        if (md == 3 && pixel_valid) begin
          e_we = 1; e_addr = ctr; e_wd = pixel_data;
          ctr++;
          if (ctr == FP) begin
            e_done = 1;
            e_cnt  = (e_cnt + 1) % 65536;
            ctr    = 0;
            md     = image_capture_enabled ? 2 : 0;
          end
        end
      end
    end
  end

  int          n_done;
  int          n_clr;
  int          n_wr;
  logic [31:0] a0_data;

  always @(negedge clk) begin
    if (started) begin
      chk("mem_we", mem_we, e_we);
      if (e_we) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
      end
      chk("frame_done", frame_done, e_done);
      chk("clear_busy", clear_busy, e_cb);
      chk("capture_busy", capture_busy, e_capb);
      chk("frame_count", frame_count, e_cnt);
      chk("frame_error", frame_error, e_err);
      n_done += int'(frame_done);
      n_clr  += int'(clear_busy);
      n_wr   += int'(mem_we);
      if (mem_we && mem_addr == 0) a0_data = mem_wdata;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [31:0] d, input bit fs);
    frame_start = fs;
    pixel_valid = 1'b1;
    pixel_data  = d;
    cyc();
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    pixel_data  = $urandom;
    repeat ($urandom_range(0, 2)) cyc();
  endtask

  task automatic zero_counts();
    n_done = 0; n_clr = 0; n_wr = 0;
  endtask

  initial begin
    zero_counts();
    a0_data = '0;
    // 1: reset with random inputs
    repeat (3) begin
      image_capture_enabled = 1'($urandom);
      clear_memory = 1'($urandom);
      frame_start  = 1'($urandom);
      pixel_valid  = 1'($urandom);
      pixel_data   = $urandom;
      cyc();
    end
    image_capture_enabled = 0; clear_memory = 0;
    frame_start = 0; pixel_valid = 0;
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_count", frame_count, 0);
    chk("rst_status",
        {clear_busy, capture_busy, frame_done, frame_error}, 0);
    reset = 0;
    cyc();

    // 2: one-cycle clear pulse
    zero_counts();
    clear_memory = 1; cyc(); clear_memory = 0;
    repeat (20) cyc();
    chk("t2_clr_cycles", n_clr, FP);
    chk("t2_clr_writes", n_wr, FP);

    // 3: full frame with random gaps
    image_capture_enabled = 1;
    cyc();
    zero_counts();
    for (int i = 0; i < FP; i++) pix(32'h100 + i, i == 0);
    repeat (3) cyc();
    chk("t3_done", n_done, 1);
    chk("t3_writes", n_wr, FP);
    chk("t3_count", frame_count, 1);
    chk("t3_busy", capture_busy, 1);

    // 4: restart mid-frame
    zero_counts();
    for (int i = 0; i < 5; i++) pix($urandom, i == 0);
    pix(32'hAA, 1);
    chk("t4_a0", a0_data, 32'hAA);
    for (int i = 1; i < FP; i++) pix($urandom, 0);
    repeat (3) cyc();
    chk("t4_err", frame_error, 1);
    chk("t4_done", n_done, 1);
    chk("t4_count", frame_count, 2);

    // 5: clear aborts a frame; held level must not retrigger
    for (int i = 0; i < 8; i++) pix($urandom, i == 0);
    zero_counts();
    clear_memory = 1;
    repeat (24) cyc();
    clear_memory = 0;
    cyc();
    chk("t5_done", n_done, 0);
    chk("t5_clr_cycles", n_clr, FP);
    chk("t5_count", frame_count, 2);
    chk("t5_err", frame_error, 0);

    // 6: enable drops mid-frame
    zero_counts();
    for (int i = 0; i < 3; i++) pix($urandom, i == 0);
    image_capture_enabled = 0;
    for (int i = 3; i < FP; i++) pix($urandom, 0);
    repeat (3) cyc();
    chk("t6_done", n_done, 1);
    chk("t6_count", frame_count, 3);
    chk("t6_busy", capture_busy, 0);
    zero_counts();
    for (int i = 0; i < 4; i++) pix($urandom, i == 0);
    repeat (3) cyc();
    chk("t6_no_writes", n_wr, 0);

    // random traffic, checked cycle by cycle against the model
    image_capture_enabled = 1;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 40) == 0)
        image_capture_enabled = ~image_capture_enabled;
      clear_memory = ($urandom_range(0, 150) == 0);
      frame_start  = ($urandom_range(0, 30) == 0);
      pixel_valid  = ($urandom_range(0, 9) < 7);
      pixel_data   = $urandom;
      cyc();
    end
    frame_start = 0; pixel_valid = 0; clear_memory = 0;
    repeat (20) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
